pit_multi_counter: RTL and testbench
====================================

// Module: pit_multi_counter
// PURPOSE
//  Parametrised 8254-style programmable interval timer: N_CH independent 16-bit down-counters
//  behind one 8-bit I/O port. Supports modes 0/2/3, binary or BCD count, counter latch,
//  read-back, and LSB/MSB/LSB-then-MSB access. Runs fully on one system clock.
//  Count clocks and gates are synchronised and edge-detected. Replaces the single-channel,
//  multi-clock-edge timer in the I/O lab SoC.
// PARAMETERS
//  N_CH    3  number of counters, 1..3; channel i at address i, control word at address 3
//  BCD_EN  1  1: BCD counting legal; 0: D0=1 in a control word is forced to binary
// PORTS
//  clk        in   1        system clock, all state on posedge
//  rflagreset in   1        reset, asynchronous, active-high
//  clk_cnt    in   N_CH     per-channel count clock, async, 2-FF synced, counts on falling edge
//  gate       in   N_CH     per-channel gate, async, 2-FF synced
//  out        out  N_CH     per-channel timer output (registered)
//  cs_n       in   1        chip select, active low
//  a          in   2        register address
//  id         in   8        write data
//  od         out  8        read data (registered)
//  ior_n      in   1        read strobe, active low, synchronous to clk
//  iow_n      in   1        write strobe, active low, synchronous to clk
// BEHAVIOUR
//  Reset: out=0, od=8'h00. Every channel idle: MR=0, CR=CE=OL=0, null_count=1, no latches,
//   read/write pointers at LSB. Reset mid-operation aborts all counting and pending reads.
//  Bus: an access fires on the single clk where cs_n=0 and the strobe goes 1->0. Writes take
//   effect the next clk. On a read, od updates the clk after the strobe edge and holds
//   until the next read. Addresses a>=N_CH other than 3 are ignored; reads of them return 8'hFF.
//  Control word (a=3): D7:6 = SC, D5:4 = RW, D3:1 = M, D0 = BCD.
//   SC=11: read-back. D5=0 latches count, D4=0 latches status, D3:1 = mask for ch2..ch0.
//   SC<N_CH, RW=00: counter latch, OL<=CE. Ignored while that channel's OL is still unread.
//   SC<N_CH, RW!=00: mode set. M in {0,2,3} only (M=6 -> 2, M=7 -> 3); M=1,4,5 ignores the word.
//    Mode set: MR<=id[5:0], null_count=1, counting stops, latches cleared, pointers reset.
//    out<=0 in mode 0, out<=1 in modes 2/3.
//   SC>=N_CH (not 11): word ignored.
//  Count write (a=i): RW=01 writes LSB (MSB=0); RW=10 writes MSB (LSB=0); RW=11 writes LSB then MSB.
//   Mode 0: out drops to 0 on the first byte write. With RW=11 counting is suspended between bytes.
//   BCD mode: a byte with a nibble >9 is discarded. Mode 3: a count of 1 is discarded.
//   In both cases the write pointer still advances.
//  Count-clock event: a falling edge of synced clk_cnt[i]. Detection latency is 3 clk from the pin.
//   CR->CE load happens on the first event after the count is complete; null_count then clears.
//   Count 0 means 65536 (binary) or 10000 (BCD).
//  Mode 0: decrement by 1 per event while gate=1. out goes 1 when CE reaches 0 and stays 1.
//   CE then wraps to FFFF/9999 and keeps counting. A new count restarts the channel with out=0.
//  Mode 2: out=1 while counting. When CE reaches 1, out=0 for one event, then CR reloads.
//   gate=0: out=1 immediately and counting holds. Gate rising edge: reload on the next event.
//   A new CR takes effect at the next reload.
//  Mode 3: CE loads CR&~1 and decrements by 2. At 2 (even CR), or at 0/2 per phase (odd CR),
//   out toggles and CE reloads. Odd CR gives a high phase of (CR+1)/2 and a low phase of (CR-1)/2.
//   gate=0 forces out=1. Gate rising edge reloads. BCD decrement borrows across nibbles.
//  Read (a=i), per channel, in priority order:
//   1. latched status {out,null_count,MR} is returned first, then released;
//   2. latched OL bytes by RW (LSB, MSB, or LSB then MSB); OL is released after its last byte;
//   3. otherwise live CE bytes by RW.
//   Status byte mirrors current state; null_count=1 until a written CR is loaded into CE.
//  Simultaneous write+event on one channel: the bus write wins; the event is applied next clk.
// TESTING
//  1. Ctrl 8'h30, cnt LSB 05, MSB 00, gate=1, 7 clk_cnt pulses:
//     out 0 until CE=0, then 1; CE wraps to FFFF.
//  2. Ctrl 8'h74, count 0004: ch1 out low for 1 of every 4 clk_cnt periods.
//     gate low mid-count forces out=1; on gate rise, count restarts from 4.
//  3. Ctrl 8'hB6, count 5: ch2 out high 3 / low 2 periods. Count 1 rejected, old CR kept.
//  4. Ctrl 8'h31 (BCD), count 0010: CE sequence 0010,0009,...,0000,9999.
//     LSB 8'h1A rejected, CE unchanged.
//  5. Latch 8'h00 at CE=0x1234, count 3 more: two reads return 34,12; a third read returns live LSB.
//  6. Read-back 8'hC2 on ch0: reads return status 8'h30 then OL bytes.
//     Assert rflagreset mid-sequence -> od=00, out=0, null_count=1.

Source files
------------

// File: rtl/pit_multi_counter.sv
// Programmable interval timer: N_CH 16-bit down-counters (modes 0/2/3, binary/BCD) behind one 8-bit port.
// Latency: writes act on the clk after the strobe edge, od the clk after; count events 3 clk after a clk_cnt fall.
// Backpressure: none; every strobe edge is taken, a count event colliding with a channel write waits one clk.
module pit_multi_counter #(
    parameter int N_CH   = 3,
    parameter bit BCD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rflagreset,
    input  logic [N_CH-1:0] clk_cnt,
    input  logic [N_CH-1:0] gate,
    output logic [N_CH-1:0] out,
    input  logic            cs_n,
    input  logic [1:0]      a,
    input  logic [7:0]      id,
    output logic [7:0]      od,
    input  logic            ior_n,
    input  logic            iow_n
);

    localparam logic [2:0] N_CH3 = 3'(N_CH);

    typedef struct packed {
        logic [5:0]  mr;          // control word bits 5:0 as written
        logic [15:0] cr;          // count register
        logic [15:0] ce;          // counting element
        logic [15:0] ol;          // output latch
        logic [7:0]  st;          // latched status
        logic [7:0]  lsb;         // first byte of an LSB-then-MSB write
        logic        ol_vld;
        logic        st_vld;
        logic        null_cnt;
        logic        wr_msb;      // next count byte is the MSB
        logic        rd_msb;      // next read byte is the MSB
        logic        run;         // CE holds a loaded count
        logic        load_pend;   // CR->CE copy on next event
        logic        reload_pend; // gate rise seen, reload on next event
        logic        evt_pend;    // event deferred by a bus write
        logic        out;
    } ch_t;

    ch_t ch_q [N_CH];
    ch_t ch_d [N_CH];

    logic            iow_n_q, iow_n_d, ior_n_q, ior_n_d;
    logic [7:0]      od_q, od_d;
    logic [N_CH-1:0] cclk_s1_q, cclk_s1_d, cclk_s2_q, cclk_s2_d, cclk_p_q, cclk_p_d;
    logic [N_CH-1:0] gate_s1_q, gate_s1_d, gate_s2_q, gate_s2_d, gate_p_q, gate_p_d;

    logic        wr_fire, rd_fire, mode_ok;
    ch_t         c, n;
    logic [1:0]  idx, md;
    logic        bcd, g, grise, ev_edge, cw_hit, rb_hit, cnt_wr, rd_hit, bad, cmpl, last;
    logic [15:0] nv, nce, src;

    // Decrement by 1 or 2 in binary or BCD; BCD borrows ripple across all four digits.
    function automatic logic [15:0] dec_cnt(input logic [15:0] v, input logic [1:0] d, input logic is_bcd);
        logic [15:0] r;
        logic [4:0]  nib;
        logic        br;
        r  = v - {14'd0, d};
        br = 1'b0;
        if (is_bcd) begin
            for (int k = 0; k < 4; k++) begin
                nib = {1'b0, v[4*k +: 4]} - ((k == 0) ? {3'd0, d} : {4'd0, br});
                if (nib[4]) begin
                    r[4*k +: 4] = nib[3:0] + 4'd10;
                    br          = 1'b1;
                end else begin
                    r[4*k +: 4] = nib[3:0];
                    br          = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Next-state logic: bus decode, synchronisers, and per-channel counting/latching.
    always_comb begin
        wr_fire   = !cs_n && iow_n_q && !iow_n;
        rd_fire   = !cs_n && ior_n_q && !ior_n;
        mode_ok   = !(id[3:1] == 3'd1 || id[3:1] == 3'd4 || id[3:1] == 3'd5);
        iow_n_d   = iow_n;
        ior_n_d   = ior_n;
        cclk_s1_d = clk_cnt;
        cclk_s2_d = cclk_s1_q;
        cclk_p_d  = cclk_s2_q;
        gate_s1_d = gate;
        gate_s2_d = gate_s1_q;
        gate_p_d  = gate_s2_q;
        od_d      = od_q;
        if (rd_fire && ({1'b0, a} >= N_CH3)) od_d = 8'hFF;
        for (int i = 0; i < N_CH; i++) begin
            c       = ch_q[i];
            n       = c;
            idx     = 2'(i);
            md      = c.mr[2:1];
            bcd     = c.mr[0];
            g       = gate_s2_q[i];
            grise   = gate_s2_q[i] & ~gate_p_q[i];
            ev_edge = cclk_p_q[i] & ~cclk_s2_q[i];
            cw_hit  = wr_fire && (a == 2'd3) && (id[7:6] == idx);
            rb_hit  = wr_fire && (a == 2'd3) && (id[7:6] == 2'b11) && id[i+1];
            cnt_wr  = wr_fire && (a == idx);
            rd_hit  = rd_fire && (a == idx);
            bad     = bcd && ((id[3:0] > 4'd9) || (id[7:4] > 4'd9));
            cmpl    = 1'b0;
            last    = 1'b1;
            nv      = '0;
            nce     = '0;
            src     = c.ol_vld ? c.ol : c.ce;

            // Gate in modes 2/3: low forces out high, a rising edge schedules a reload.
            if (md != 2'b00) begin
                if (!g) n.out = 1'b1;
                if (grise) n.reload_pend = 1'b1;
            end

            // Count events; a write addressed to this channel owns the clk.
            if (cw_hit || cnt_wr) begin
                n.evt_pend = c.evt_pend | ev_edge;
            end else begin
                n.evt_pend = 1'b0;
                if (ev_edge || c.evt_pend) begin
                    if (c.load_pend) begin
                        n.ce          = (md == 2'b11) ? {c.cr[15:1], 1'b0} : c.cr;
                        n.load_pend   = 1'b0;
                        n.reload_pend = 1'b0;
                        n.run         = 1'b1;
                        n.null_cnt    = 1'b0;
                        if (md != 2'b00) n.out = 1'b1;
                    end else if (c.run && g) begin
                        case (md)
                            2'b00: begin
                                nce  = dec_cnt(c.ce, 2'd1, bcd);
                                n.ce = nce;
                                if (nce == 16'd0) n.out = 1'b1;
                            end
                            2'b10: begin
                                if (n.reload_pend || c.ce == 16'd1) begin
                                    n.ce          = c.cr;
                                    n.out         = 1'b1;
                                    n.null_cnt    = 1'b0;
                                    n.reload_pend = 1'b0;
                                end else begin
                                    nce  = dec_cnt(c.ce, 2'd1, bcd);
                                    n.ce = nce;
                                    if (nce == 16'd1) n.out = 1'b0;
                                end
                            end
                            2'b11: begin
                                if (n.reload_pend) begin
                                    n.ce          = {c.cr[15:1], 1'b0};
                                    n.out         = 1'b1;
                                    n.null_cnt    = 1'b0;
                                    n.reload_pend = 1'b0;
                                end else if (c.ce == ((c.out && c.cr[0]) ? 16'd0 : 16'd2)) begin
                                    // odd counts stretch the high phase by one event
                                    n.ce       = {c.cr[15:1], 1'b0};
                                    n.out      = !c.out;
                                    n.null_cnt = 1'b0;
                                end else begin
                                    n.ce = dec_cnt(c.ce, 2'd2, bcd);
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end

            // Control word for this channel: counter latch or mode set.
            if (cw_hit) begin
                if (id[5:4] == 2'b00) begin
                    if (!c.ol_vld) begin
                        n.ol     = c.ce;
                        n.ol_vld = 1'b1;
                        n.rd_msb = 1'b0;
                    end
                end else if (mode_ok) begin
                    n.mr          = {id[5:1], id[0] & BCD_EN};
                    n.null_cnt    = 1'b1;
                    n.run         = 1'b0;
                    n.load_pend   = 1'b0;
                    n.reload_pend = 1'b0;
                    n.evt_pend    = 1'b0;
                    n.ol_vld      = 1'b0;
                    n.st_vld      = 1'b0;
                    n.wr_msb      = 1'b0;
                    n.rd_msb      = 1'b0;
                    n.out         = (id[2:1] != 2'b00);
                end
            end

            // Read-back: latch count and/or status, never overwriting an unread latch.
            if (rb_hit) begin
                if (!id[5] && !c.ol_vld) begin
                    n.ol     = c.ce;
                    n.ol_vld = 1'b1;
                    n.rd_msb = 1'b0;
                end
                if (!id[4] && !c.st_vld) begin
                    n.st     = {c.out, c.null_cnt, c.mr};
                    n.st_vld = 1'b1;
                end
            end

            // Count byte writes; rejected bytes still advance the write pointer.
            if (cnt_wr) begin
                case (c.mr[5:4])
                    2'b01: begin cmpl = !bad; nv = {8'h00, id}; end
                    2'b10: begin cmpl = !bad; nv = {id, 8'h00}; end
                    2'b11: begin
                        n.wr_msb = !c.wr_msb;
                        if (!c.wr_msb) begin
                            if (!bad) begin
                                n.lsb = id;
                                if (md == 2'b00) begin
                                    n.out       = 1'b0;
                                    n.run       = 1'b0;
                                    n.load_pend = 1'b0;
                                end
                            end
                        end else begin
                            cmpl = !bad;
                            nv   = {id, c.lsb};
                        end
                    end
                    default: ;
                endcase
                if (cmpl && !(md == 2'b11 && nv == 16'd1)) begin
                    n.cr       = nv;
                    n.null_cnt = 1'b1;
                    if (md == 2'b00 || !c.run) begin
                        n.load_pend = 1'b1;
                        n.run       = 1'b0;
                    end
                    if (md == 2'b00) n.out = 1'b0;
                end
            end

            // Reads: status first, then latched count, then live count.
            if (rd_hit) begin
                if (c.st_vld) begin
                    od_d     = c.st;
                    n.st_vld = 1'b0;
                end else begin
                    case (c.mr[5:4])
                        2'b10: od_d = src[15:8];
                        2'b11: begin
                            od_d     = c.rd_msb ? src[15:8] : src[7:0];
                            last     = c.rd_msb;
                            n.rd_msb = !c.rd_msb;
                        end
                        default: od_d = src[7:0];
                    endcase
                    if (c.ol_vld && last) n.ol_vld = 1'b0;
                end
            end

            ch_d[i] = n;
        end
    end

    // State register with asynchronous reset to the idle, null-count state.
    always_ff @(posedge clk or posedge rflagreset) begin
        if (rflagreset) begin
            iow_n_q   <= 1'b1;
            ior_n_q   <= 1'b1;
            od_q      <= '0;
            cclk_s1_q <= '0;
            cclk_s2_q <= '0;
            cclk_p_q  <= '0;
            gate_s1_q <= '0;
            gate_s2_q <= '0;
            gate_p_q  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                ch_q[i]          <= '0;
                ch_q[i].null_cnt <= 1'b1;
            end
        end else begin
            iow_n_q   <= iow_n_d;
            ior_n_q   <= ior_n_d;
            od_q      <= od_d;
            cclk_s1_q <= cclk_s1_d;
            cclk_s2_q <= cclk_s2_d;
            cclk_p_q  <= cclk_p_d;
            gate_s1_q <= gate_s1_d;
            gate_s2_q <= gate_s2_d;
            gate_p_q  <= gate_p_d;
            for (int i = 0; i < N_CH; i++) ch_q[i] <= ch_d[i];
        end
    end

    // Registered outputs.
    always_comb begin
        out = '0;
        for (int i = 0; i < N_CH; i++) out[i] = ch_q[i].out;
    end

    assign od = od_q;

endmodule

// File: tb/tb_pit_multi_counter.sv
// Directed bench for pit_multi_counter: mode 0/2/3, BCD, latch, read-back, reset.
// Expected values are hand-computed per count-clock event.
// All comparisons go through chk().
module tb_pit_multi_counter;

    logic       clk = 1'b0;
    logic       rflagreset, cs_n, ior_n, iow_n;
    logic [2:0] clk_cnt, gate, out;
    logic [1:0] a;
    logic [7:0] id, od;
    logic [7:0] rb;
    logic [15:0] rw16;
    logic [15:0] exp16;
    int n_chk  = 0;
    int n_fail = 0;

    bit t2_pat [0:7]  = '{1, 1, 1, 0, 1, 1, 1, 0};
    bit t3_pat [0:10] = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 1};

    pit_multi_counter #(.N_CH(3), .BCD_EN(1'b1)) dut (
        .clk        (clk),
        .rflagreset (rflagreset),
        .clk_cnt    (clk_cnt),
        .gate       (gate),
        .out        (out),
        .cs_n       (cs_n),
        .a          (a),
        .id         (id),
        .od         (od),
        .ior_n      (ior_n),
        .iow_n      (iow_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [1:0] addr, input logic [7:0] d);
        @(negedge clk);
        cs_n = 1'b0; a = addr; id = d; iow_n = 1'b0;
        @(negedge clk);
        iow_n = 1'b1; cs_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic bus_rd(input logic [1:0] addr, output logic [7:0] d);
        @(negedge clk);
        cs_n = 1'b0; a = addr; ior_n = 1'b0;
        @(negedge clk);
        ior_n = 1'b1; cs_n = 1'b1;
        d = od;
        @(negedge clk);
    endtask

    task automatic rd16(input logic [1:0] addr, output logic [15:0] v);
        logic [7:0] lo, hi;
        bus_rd(addr, lo);
        bus_rd(addr, hi);
        v = {hi, lo};
    endtask

    task automatic pulse(input int ch);
        @(negedge clk);
        clk_cnt[ch] = 1'b1;
        repeat (4) @(negedge clk);
        clk_cnt[ch] = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rflagreset = 1'b1; cs_n = 1'b1; ior_n = 1'b1; iow_n = 1'b1;
        a = 2'd0; id = 8'h00; clk_cnt = 3'b000; gate = 3'b111;
        repeat (3) @(negedge clk);
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_od", 32'(od), 32'h00);
        rflagreset = 1'b0;
        repeat (2) @(negedge clk);

        bus_rd(2'd3, rb);
        chk("rd_ctrl_addr", 32'(rb), 32'hFF);
        bus_wr(2'd3, 8'hE2);
        bus_rd(2'd0, rb);
        chk("rst_status_ch0", 32'(rb), 32'h40);

        // Mode 2 on ch1, count 4, gate low then high
        bus_wr(2'd3, 8'h74);
        chk("t2_modeset_out", 32'(out[1]), 32'h1);
        bus_wr(2'd1, 8'h04);
        bus_wr(2'd1, 8'h00);
        for (int k = 0; k < 8; k++) begin
            pulse(1);
            chk($sformatf("t2_out_p%0d", k + 1), 32'(out[1]), 32'(t2_pat[k]));
        end
        gate[1] = 1'b0;
        repeat (4) @(negedge clk);
        chk("t2_gate_low_out", 32'(out[1]), 32'h1);
        pulse(1);
        rd16(2'd1, rw16);
        chk("t2_gate_low_hold", 32'(rw16), 32'h0001);
        gate[1] = 1'b1;
        repeat (4) @(negedge clk);
        pulse(1);
        rd16(2'd1, rw16);
        chk("t2_gate_rise_reload", 32'(rw16), 32'h0004);
        chk("t2_gate_rise_out", 32'(out[1]), 32'h1);
        for (int k = 0; k < 3; k++) begin
            pulse(1);
            chk($sformatf("t2_after_rise_p%0d", k + 1), 32'(out[1]), (k == 2) ? 32'h0 : 32'h1);
        end

        // Mode 3 on ch2, count 5 (3 high / 2 low), count 1 rejected
        bus_wr(2'd3, 8'hB6);
        bus_wr(2'd2, 8'h05);
        bus_wr(2'd2, 8'h00);
        for (int k = 0; k < 11; k++) begin
            pulse(2);
            chk($sformatf("t3_out_p%0d", k + 1), 32'(out[2]), 32'(t3_pat[k]));
        end
        bus_wr(2'd2, 8'h01);
        bus_wr(2'd2, 8'h00);
        bus_wr(2'd3, 8'hE8);
        bus_rd(2'd2, rb);
        chk("t3_status_after_cnt1", 32'(rb), 32'hB6);
        pulse(2);
        pulse(2);
        chk("t3_old_cr_high", 32'(out[2]), 32'h1);
        pulse(2);
        chk("t3_old_cr_toggle", 32'(out[2]), 32'h0);

        // Mode 0 BCD on ch0, count 0010
        bus_wr(2'd3, 8'h31);
        bus_wr(2'd0, 8'h10);
        bus_wr(2'd0, 8'h00);
        for (int k = 0; k < 12; k++) begin
            pulse(0);
            rd16(2'd0, rw16);
            if (k == 0) exp16 = 16'h0010;
            else if (k == 11) exp16 = 16'h9999;
            else exp16 = 16'(10 - k);
            chk($sformatf("t4_bcd_ce_p%0d", k + 1), 32'(rw16), 32'(exp16));
        end
        chk("t4_bcd_out", 32'(out[0]), 32'h1);
        bus_wr(2'd0, 8'h1A);
        rd16(2'd0, rw16);
        chk("t4_bad_lsb_ce", 32'(rw16), 32'h9999);
        chk("t4_bad_lsb_out", 32'(out[0]), 32'h1);

        // Mode 0 binary on ch0, count 5, 7 pulses
        bus_wr(2'd3, 8'h30);
        chk("t1_modeset_out", 32'(out[0]), 32'h0);
        bus_wr(2'd0, 8'h05);
        bus_wr(2'd0, 8'h00);
        bus_wr(2'd3, 8'hE2);
        bus_rd(2'd0, rb);
        chk("t1_status_null", 32'(rb), 32'h70);
        pulse(0);
        rd16(2'd0, rw16);
        chk("t1_load_ce", 32'(rw16), 32'h0005);
        for (int k = 2; k <= 5; k++) begin
            pulse(0);
            chk($sformatf("t1_out_p%0d", k), 32'(out[0]), 32'h0);
        end
        pulse(0);
        chk("t1_out_terminal", 32'(out[0]), 32'h1);
        rd16(2'd0, rw16);
        chk("t1_ce_zero", 32'(rw16), 32'h0000);
        pulse(0);
        rd16(2'd0, rw16);
        chk("t1_ce_wrap", 32'(rw16), 32'hFFFF);
        chk("t1_out_stays", 32'(out[0]), 32'h1);

        // Counter latch at 0x1234
        bus_wr(2'd0, 8'h37);
        bus_wr(2'd0, 8'h12);
        chk("t5_newcnt_out", 32'(out[0]), 32'h0);
        for (int k = 0; k < 4; k++) pulse(0);
        bus_wr(2'd3, 8'h00);
        for (int k = 0; k < 3; k++) pulse(0);
        bus_wr(2'd3, 8'h00);
        bus_rd(2'd0, rb);
        chk("t5_ol_lsb", 32'(rb), 32'h34);
        bus_rd(2'd0, rb);
        chk("t5_ol_msb", 32'(rb), 32'h12);
        bus_rd(2'd0, rb);
        chk("t5_live_lsb", 32'(rb), 32'h31);
        bus_rd(2'd0, rb);
        chk("t5_live_msb", 32'(rb), 32'h12);

        // Read-back status + count, reset mid-sequence
        bus_wr(2'd3, 8'hC2);
        bus_rd(2'd0, rb);
        chk("t6_status", 32'(rb), 32'h30);
        bus_rd(2'd0, rb);
        chk("t6_ol_lsb", 32'(rb), 32'h31);
        @(negedge clk);
        rflagreset = 1'b1;
        #1;
        chk("t6_rst_od", 32'(od), 32'h00);
        chk("t6_rst_out", 32'(out), 32'h0);
        repeat (2) @(negedge clk);
        rflagreset = 1'b0;
        repeat (2) @(negedge clk);
        bus_wr(2'd3, 8'hE2);
        bus_rd(2'd0, rb);
        chk("t6_rst_status", 32'(rb), 32'h40);
        repeat (3) @(negedge clk);
        chk("od_hold", 32'(od), 32'h40);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
